// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encodings, FSM states
// and the iteration-counter width. The divider is built only when MDU_DIV_EN is defined.
package mdu_pkg;

   localparam int MDU_XLEN = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } mdu_state_e;

   function automatic int mdu_cnt_w(input int xlen);
      return $clog2(xlen);
   endfunction

   localparam int MDU_CNT_W = mdu_cnt_w(MDU_XLEN);

   function automatic logic mdu_is_div(input logic [1:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic mdu_is_signed(input logic [1:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-divide iteration on unsigned magnitudes: shifts the next dividend bit
// into the partial remainder and produces one quotient bit. Used only under MDU_DIV_EN.
module mdu_div_step
   import mdu_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // rem < divisor holds on entry, so the top bit of diff is a clean borrow flag.
   always_comb begin
      shifted = {rem, quo[XLEN-1]};
      diff    = shifted - {1'b0, divisor};
      if (!diff[XLEN]) begin
         rem_next = diff[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b1};
      end else begin
         rem_next = shifted[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU finish at once with div_err.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int XLEN = MDU_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   input  logic            wr_hi,
   input  logic            wr_lo,
   input  logic [XLEN-1:0] wr_data,
   output logic            busy,
   output logic            done,
   output logic            div_err,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = mdu_cnt_w(XLEN);

   mdu_state_e        state;
   mdu_state_e        state_nxt;
   logic [CW-1:0]     cnt;
   logic              is_div_q;
   logic              sign_a;
   logic              sign_b;
   logic              err_q;
   logic [XLEN-1:0]   b_mag;
   logic [2*XLEN-1:0] acc;

   logic              launch;
   logic              launch_div;
   logic              skip_calc;
   logic              sa;
   logic              sb;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag_in;
   logic [XLEN-1:0]   acc_lo_load;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_nxt;
   logic [2*XLEN-1:0] step_nxt;
   logic [2*XLEN-1:0] prod_fix;

   assign launch     = (state == S_IDLE) && start;
   assign launch_div = launch && mdu_is_div(op);
   assign busy       = (state != S_IDLE);

   always_comb begin
      sa       = mdu_is_signed(op) && rs_data[XLEN-1];
      sb       = mdu_is_signed(op) && rt_data[XLEN-1];
      a_mag    = sa ? (~rs_data + 1'b1) : rs_data;
      b_mag_in = sb ? (~rt_data + 1'b1) : rt_data;
   end

   // Shift-add: multiplier sits in the low half and is consumed LSB first.
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
      mul_nxt = {mul_sum, acc[XLEN-1:1]};
   end

   assign prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;

`ifdef MDU_DIV_EN
   logic            div_zero;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;
   logic [XLEN-1:0] rem_fix;
   logic [XLEN-1:0] quo_fix;

   assign div_zero  = (rt_data == '0);
   assign skip_calc = launch_div && div_zero;
   // A zero divisor keeps the raw dividend so FIX can hand it straight to HI.
   assign acc_lo_load = (launch_div && div_zero) ? rs_data : a_mag;

   mdu_div_step #(
      .XLEN (XLEN)
   ) u_div_step (
      .rem      (acc[2*XLEN-1:XLEN]),
      .quo      (acc[XLEN-1:0]),
      .divisor  (b_mag),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   assign step_nxt = is_div_q ? {rem_next, quo_next} : mul_nxt;
   assign quo_fix  = (sign_a ^ sign_b) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
   assign rem_fix  = sign_a ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
`else
   assign skip_calc   = launch_div;
   assign acc_lo_load = a_mag;
   assign step_nxt    = mul_nxt;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = skip_calc ? S_FIX : S_CALC;
         S_CALC:  if (cnt == '0) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_err  <= 1'b0;
         acc      <= '0;
         cnt      <= '0;
         b_mag    <= '0;
         is_div_q <= 1'b0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done    <= 1'b0;
         div_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (wr_hi) hi <= wr_data;
               if (wr_lo) lo <= wr_data;
               if (launch) begin
                  is_div_q <= mdu_is_div(op);
                  sign_a   <= sa;
                  sign_b   <= sb;
                  b_mag    <= b_mag_in;
                  acc      <= {{XLEN{1'b0}}, acc_lo_load};
                  cnt      <= CW'(XLEN - 1);
                  err_q    <= skip_calc;
               end
            end
            S_CALC: begin
               acc <= step_nxt;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            S_FIX: begin
               done <= 1'b1;
               if (!is_div_q) begin
                  {hi, lo} <= prod_fix;
               end else begin
                  div_err <= err_q;
`ifdef MDU_DIV_EN
                  if (err_q) begin
                     hi <= acc[XLEN-1:0];
                     lo <= '1;
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
